mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the single-cycle-to-multi-cycle datapath migration. It is the driving end of the ALU control interface: it decodes the instruction register fields, sequences fetch, decode, execute, memory and writeback, and issues the 3-bit ALU control code. It consumes the ALU's Zero and Overflow flags for branch resolution and arithmetic-overflow exceptions.

## Interface
- No parameters; the ALU control encoding is fixed: 000 addu, 001 add (ovf), 010 or, 100 subu, 101 sub (ovf), 110 sltu, 111 slt.
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- op  in  6  IR[31:26], valid from ID onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU Zero
- overflow  in  1  ALU Overflow (already gated by ALU to add/sub codes)
- mem_ready  in  1  memory completes the current access this cycle
- pc_wr  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 branch target reg, 10 jump target, 11 exception vector
- ir_wr  out  1  IR load enable
- mem_rd / mem_wr  out  1 each  memory request strobes
- reg_wr  out  1  register file write
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = memory data, 0 = ALU out
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
- ext_op  out  1  1 = sign-extend, 0 = zero-extend
- alu_ctr  out  3  ALU control code
- exc  out  1  one-cycle exception pulse
- state  out  3  current state, for debug

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, EXC=5. Encodings 6 and 7 go to IF on the next clock.
- Outputs are decoded from the state, op and funct. Any output not listed for a state is 0.
- IF:
  - Drive mem_rd=1, alu_src_a=0, alu_src_b=01, alu_ctr=000, pc_src=00.
  - While mem_ready=0: hold the state; ir_wr and pc_wr stay 0.
  - When mem_ready=1: ir_wr=1, pc_wr=1, next state ID.
- ID:
  - Drive alu_src_a=0, alu_src_b=11, ext_op=1, alu_ctr=000; the branch target is latched by the datapath.
  - j (000010): pc_wr=1, pc_src=10, next state IF.
  - Legal op: next state EX.
  - Illegal op, or R-type with an unsupported funct: next state EXC.
- Legal set:
  - R-type (op 000000) funct: 100000 add, 100001 addu, 100010 sub, 100011 subu, 100101 or, 101010 slt, 101011 sltu.
  - I-type op: 001000 addi, 001001 addiu, 001101 ori, 100011 lw, 101011 sw, 000100 beq, 000010 j.
- EX (alu_src_a=1):
  - R-type: alu_src_b=00; alu_ctr per funct, in the listed order: 001, 000, 101, 100, 010, 111, 110.
  - addi: alu_src_b=10, ext_op=1, alu_ctr=001.
  - addiu, lw, sw: alu_src_b=10, ext_op=1, alu_ctr=000.
  - ori: alu_src_b=10, ext_op=0, alu_ctr=010.
  - beq: alu_src_b=00, alu_ctr=100, pc_src=01, pc_wr=zero; next state IF.
  - overflow=1: next state EXC; no writeback.
  - Otherwise lw/sw go to MEM and all others go to WB.
- MEM:
  - lw drives mem_rd=1; sw drives mem_wr=1.
  - Hold the state until mem_ready=1, then lw goes to WB and sw goes to IF.
- WB:
  - reg_wr=1; reg_dst=1 for R-type; mem_to_reg=1 for lw.
  - Next state IF.
- EXC: exc=1, pc_wr=1, pc_src=11, next state IF.

## Timing
- Reset: with rst_n=0 at a clock edge, the state becomes IF. While rst_n=0, every output is forced to 0 combinationally, including mem_rd and state.
- Reset mid-access (IF or MEM wait): the access is abandoned; no write strobe is issued after the reset edge.
- Cycles per instruction, with zero memory wait:
  - j: 2
  - beq: 3
  - R-type and immediate ALU ops: 4
  - sw: 4
  - lw: 5
  - overflow trap: 4 (IF, ID, EX, EXC)
  - Each memory wait cycle adds 1.
- mem_ready is sampled only in IF and MEM and ignored in other states.
- pc_wr in EX is combinational from zero in the same cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1, then release.
  - While rst_n=0, all outputs are 0.
  - First cycle after release: state=0, mem_rd=1, alu_ctr=000.
- addu R-type (op=0, funct=100001), mem_ready=1 always.
  - State sequence 0,1,2,4,0.
  - EX: alu_ctr=000, alu_src_b=00.
  - WB: reg_wr=1, reg_dst=1.
- lw with mem_ready low for 2 cycles in MEM.
  - State sequence 0,1,2,3,3,3,4,0.
  - mem_rd=1 throughout MEM.
  - WB: mem_to_reg=1.
- beq with zero=1, then repeat with zero=0.
  - EX: pc_wr is 1 for zero=1 and 0 for zero=0; pc_src=01.
  - Next state is IF in both cases.
- add with overflow=1 in EX.
  - EX: alu_ctr=001.
  - Next state is EXC with exc=1, pc_src=11.
  - reg_wr is never asserted.
- Illegal op 111111 in ID: next state EXC, exc pulses exactly 1 cycle, then IF.
- sw, additional check: mem_wr=1 only in MEM; then IF.

Source files
------------

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle control unit: IF/ID/EX/MEM/WB/EXC sequencer and ALU control decode
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [2:0] alu_ctr,
  output logic       exc,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t cur;
  state_t nxt;

  logic       is_r, is_addi, is_addiu, is_ori, is_lw, is_sw, is_beq, is_j;
  logic       legal;
  logic       r_ok;
  logic [2:0] r_alu;

  assign is_r     = (op == OP_R);
  assign is_addi  = (op == OP_ADDI);
  assign is_addiu = (op == OP_ADDIU);
  assign is_ori   = (op == OP_ORI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign legal    = (is_r & r_ok) | is_addi | is_addiu | is_ori | is_lw | is_sw | is_beq | is_j;

  // R-type funct to ALU control code; unsupported functs are flagged illegal
  always_comb begin
    r_ok  = 1'b1;
    r_alu = 3'b000;
    case (funct)
      6'b100000: r_alu = 3'b001;
      6'b100001: r_alu = 3'b000;
      6'b100010: r_alu = 3'b101;
      6'b100011: r_alu = 3'b100;
      6'b100101: r_alu = 3'b010;
      6'b101010: r_alu = 3'b111;
      6'b101011: r_alu = 3'b110;
      default:   r_ok  = 1'b0;
    endcase
  end

  // Next-state and control output decode; all outputs held at 0 while in reset
  always_comb begin
    nxt        = cur;
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    ir_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 1'b0;
    alu_ctr    = 3'b000;
    exc        = 1'b0;
    state      = cur;
    case (cur)
      S_IF: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
          nxt   = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        if (is_j) begin
          pc_wr  = 1'b1;
          pc_src = 2'b10;
          nxt    = S_IF;
        end else if (legal) begin
          nxt = S_EX;
        end else begin
          nxt = S_EXC;
        end
      end
      S_EX: begin
        alu_src_a = 1'b1;
        if (is_r) begin
          alu_src_b = 2'b00;
          alu_ctr   = r_alu;
        end else if (is_addi) begin
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
          alu_ctr   = 3'b001;
        end else if (is_addiu || is_lw || is_sw) begin
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
        end else if (is_ori) begin
          alu_src_b = 2'b10;
          alu_ctr   = 3'b010;
        end else if (is_beq) begin
          alu_ctr = 3'b100;
          pc_src  = 2'b01;
          pc_wr   = zero;
        end
        if (is_beq)
          nxt = S_IF;
        else if (overflow)
          nxt = S_EXC;
        else if (is_lw || is_sw)
          nxt = S_MEM;
        else
          nxt = S_WB;
      end
      S_MEM: begin
        mem_rd = is_lw;
        mem_wr = is_sw;
        if (mem_ready)
          nxt = is_lw ? S_WB : S_IF;
      end
      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        nxt        = S_IF;
      end
      S_EXC: begin
        exc    = 1'b1;
        pc_wr  = 1'b1;
        pc_src = 2'b11;
        nxt    = S_IF;
      end
      default: nxt = S_IF;
    endcase
    if (!rst_n) begin
      pc_wr      = 1'b0;
      pc_src     = 2'b00;
      ir_wr      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_op     = 1'b0;
      alu_ctr    = 3'b000;
      exc        = 1'b0;
      state      = 3'b000;
    end
  end

  // State register with synchronous active-low reset to IF
  always_ff @(posedge clk) begin
    if (!rst_n)
      cur <= S_IF;
    else
      cur <= nxt;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against a per-instruction cycle trace model
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, overflow, mem_ready;
  logic       pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, alu_src_a, ext_op, exc;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctr, state;
  logic [19:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_ctr(alu_ctr),
    .exc(exc), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {pc_wr, pc_src, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, ext_op, alu_ctr, exc, state};

  typedef struct packed {
    logic        rdy;
    logic        z;
    logic        ov;
    logic [19:0] exp;
  } cyc_t;

  cyc_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%05h exp=%05h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] pk(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
                                     input logic irw, input logic mrd, input logic mwr, input logic rw,
                                     input logic rd, input logic m2r, input logic sa, input logic [1:0] sb,
                                     input logic ext, input logic [2:0] alu, input logic ex);
    return {pcw, pcs, irw, mrd, mwr, rw, rd, m2r, sa, sb, ext, alu, ex, st};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle trace of one instruction, derived from its class and the stimulus chosen for it
  task automatic build(input logic [5:0] o, input logic [5:0] f, input int if_w, input int mem_w,
                       input logic z, input logic ovf);
    int         cls;  // 0 R, 1 alu-imm, 2 lw, 3 sw, 4 beq, 5 j, 6 illegal
    logic [2:0] alu;
    logic [1:0] sb;
    logic       ext, ov_able, ov;
    cls = 6; alu = 3'b000; sb = 2'b00; ext = 1'b0; ov_able = 1'b0;
    case (o)
      6'b000000: begin
        cls = 0;
        case (f)
          6'b100000: alu = 3'b001;
          6'b100001: alu = 3'b000;
          6'b100010: alu = 3'b101;
          6'b100011: alu = 3'b100;
          6'b100101: alu = 3'b010;
          6'b101010: alu = 3'b111;
          6'b101011: alu = 3'b110;
          default:   cls = 6;
        endcase
        ov_able = (alu == 3'b001) || (alu == 3'b101);
      end
      6'b001000: begin cls = 1; alu = 3'b001; sb = 2'b10; ext = 1'b1; ov_able = 1'b1; end
      6'b001001: begin cls = 1; sb = 2'b10; ext = 1'b1; end
      6'b001101: begin cls = 1; alu = 3'b010; sb = 2'b10; end
      6'b100011: begin cls = 2; sb = 2'b10; ext = 1'b1; end
      6'b101011: begin cls = 3; sb = 2'b10; ext = 1'b1; end
      6'b000100: begin cls = 4; alu = 3'b100; end
      6'b000010: cls = 5;
      default:   cls = 6;
    endcase
    ov = ovf & ov_able;
    op = o; funct = f;
    for (int i = 0; i < if_w; i++)
      q.push_back('{1'b0, rbit(), 1'b0, pk(3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 0)});
    q.push_back('{1'b1, rbit(), 1'b0, pk(3'd0, 1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 0)});
    q.push_back('{rbit(), rbit(), 1'b0, pk(3'd1, cls == 5, (cls == 5) ? 2'b10 : 2'b00, 0, 0, 0, 0, 0, 0, 0,
                                          2'b11, 1, 3'b000, 0)});
    if (cls == 5) return;
    if (cls != 6) begin
      q.push_back('{rbit(), z, ov, pk(3'd2, (cls == 4) & z, (cls == 4) ? 2'b01 : 2'b00, 0, 0, 0, 0, 0, 0, 1,
                                      sb, ext, alu, 0)});
      if (cls == 4) return;
    end
    if (cls == 6 || ov) begin
      q.push_back('{rbit(), rbit(), 1'b0, pk(3'd5, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 1)});
      return;
    end
    if (cls == 2 || cls == 3) begin
      for (int i = 0; i <= mem_w; i++)
        q.push_back('{i == mem_w, rbit(), 1'b0, pk(3'd3, 0, 2'b00, 0, cls == 2, cls == 3, 0, 0, 0, 0,
                                                   2'b00, 0, 3'b000, 0)});
      if (cls == 3) return;
    end
    q.push_back('{rbit(), rbit(), 1'b0, pk(3'd4, 0, 2'b00, 0, 0, 0, 1, cls == 0, cls == 2, 0, 2'b00, 0,
                                          3'b000, 0)});
  endtask

  // Play up to n queued cycles (n < 0: all), starting and ending 1 time unit after a rising edge
  task automatic exec(input int n);
    int lim;
    lim = (n < 0 || n > q.size()) ? q.size() : n;
    for (int i = 0; i < lim; i++) begin
      mem_ready = q[i].rdy; zero = q[i].z; overflow = q[i].ov;
      @(negedge clk);
      check($sformatf("trace_st%0d", q[i].exp[2:0]), {12'd0, obs}, {12'd0, q[i].exp});
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  logic [5:0] lop [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                           6'b001000, 6'b001001, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
  logic [5:0] lfn [7]  = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100101, 6'b101010, 6'b101011};

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; op = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", {12'd0, obs}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    build(6'b000000, 6'b100001, 0, 0, 0, 0); exec(-1);   // addu
    build(6'b100011, 6'h15,     0, 2, 0, 0); exec(-1);   // lw, 2 wait cycles in MEM
    build(6'b000100, 6'h2a,     0, 0, 1, 0); exec(-1);   // beq taken
    build(6'b000100, 6'h2a,     0, 0, 0, 0); exec(-1);   // beq not taken
    build(6'b000000, 6'b100000, 0, 0, 0, 1); exec(-1);   // add overflow trap
    build(6'b111111, 6'h00,     0, 0, 0, 0); exec(-1);   // illegal op
    build(6'b000000, 6'b111111, 1, 0, 0, 0); exec(-1);   // unsupported funct
    build(6'b101011, 6'h07,     1, 1, 0, 0); exec(-1);   // sw with waits
    build(6'b000010, 6'h01,     0, 0, 0, 0); exec(-1);   // j

    // Reset during a store's MEM wait: access abandoned, no write strobe afterwards
    build(6'b101011, 6'h00, 0, 3, 0, 0);
    exec(4);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", {12'd0, obs}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mid_state", {12'd0, obs}, {12'd0, pk(3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 0)});
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      logic [5:0] o, f;
      int sel;
      sel = $urandom_range(0, 16);
      if (sel < 14) begin
        o = lop[sel];
        f = (sel < 7) ? lfn[sel] : 6'($urandom);
      end else if (sel == 14) begin
        o = 6'($urandom); f = 6'($urandom);
      end else begin
        o = 6'h00; f = 6'($urandom);
      end
      build(o, f, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
            ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
            rbit(), $urandom_range(0, 3) == 0);
      exec(-1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
